// File: rtl/online_max_tracker.sv
// Running row-maximum tracker for the online-softmax step: consumes the score
// stream, emits s - m_new and m_old - m_new (saturated) plus row framing flags.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 4
`endif

module online_max_tracker #(
  parameter int SCORE_W = 8,
  parameter int SEQ_LEN = `MAX_SEQ_LENGTH,
  parameter int CNT_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      vld_in,
  output logic                      rdy_out,
  input  logic signed [SCORE_W-1:0] s_in,
  output logic                      vld_out,
  input  logic                      rdy_in,
  output logic signed [SCORE_W-1:0] diff_out,
  output logic signed [SCORE_W-1:0] mdiff_out,
  output logic signed [SCORE_W-1:0] max_out,
  output logic                      first_out,
  output logic                      last_out
);

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(SEQ_LEN - 1);

  logic        [CNT_W-1:0]   cnt;
  logic signed [SCORE_W-1:0] m_reg;

  logic                      accept;
  logic                      is_first;
  logic                      is_last;
  logic signed [SCORE_W-1:0] m_new;
  logic signed [SCORE_W:0]   diff_raw;
  logic signed [SCORE_W:0]   mdiff_raw;

  // Clamp a (SCORE_W+1)-bit difference into SCORE_W bits; the negative rail is
  // the only one reachable, the positive rail exists only for completeness.
  function automatic logic [SCORE_W-1:0] sat(input logic [SCORE_W:0] raw);
    if (raw[SCORE_W] != raw[SCORE_W-1])
      return raw[SCORE_W] ? {1'b1, {(SCORE_W-1){1'b0}}} : {1'b0, {(SCORE_W-1){1'b1}}};
    else
      return raw[SCORE_W-1:0];
  endfunction

  // An output drains and a new score lands in the same cycle.
  assign rdy_out  = !vld_out || rdy_in;
  assign accept   = vld_in && rdy_out;
  assign is_first = (cnt == '0);
  assign is_last  = (cnt == LAST_POS);

  always_comb begin
    m_new = m_reg;
    if (is_first || (s_in > m_reg))
      m_new = s_in;
    diff_raw  = {s_in[SCORE_W-1], s_in} - {m_new[SCORE_W-1], m_new};
    mdiff_raw = {m_reg[SCORE_W-1], m_reg} - {m_new[SCORE_W-1], m_new};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_out   <= 1'b0;
      diff_out  <= '0;
      mdiff_out <= '0;
      max_out   <= '0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
      cnt       <= '0;
      m_reg     <= '0;
    end else if (accept) begin
      vld_out   <= 1'b1;
      diff_out  <= sat(diff_raw);
      mdiff_out <= is_first ? '0 : sat(mdiff_raw);
      max_out   <= m_new;
      first_out <= is_first;
      last_out  <= is_last;
      cnt       <= is_last ? '0 : cnt + 1'b1;
      m_reg     <= m_new;
    end else if (rdy_in) begin
      // Drained with nothing new: only the valid drops, data is left as is.
      vld_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_online_max_tracker.sv
// Directed bench for online_max_tracker with SEQ_LEN=4, SCORE_W=8; expected
// values are hand-computed from the max/difference/saturation rules.
module tb_online_max_tracker;

  logic              clock = 1'b0;
  logic              reset;
  logic              vld_in;
  logic              rdy_out;
  logic signed [7:0] s_in;
  logic              vld_out;
  logic              rdy_in;
  logic signed [7:0] diff_out;
  logic signed [7:0] mdiff_out;
  logic signed [7:0] max_out;
  logic              first_out;
  logic              last_out;

  int n_checks = 0;
  int n_fail   = 0;

  online_max_tracker #(.SCORE_W(8), .SEQ_LEN(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .vld_in   (vld_in),
    .rdy_out  (rdy_out),
    .s_in     (s_in),
    .vld_out  (vld_out),
    .rdy_in   (rdy_in),
    .diff_out (diff_out),
    .mdiff_out(mdiff_out),
    .max_out  (max_out),
    .first_out(first_out),
    .last_out (last_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_res(input string tag, input int d, input int md, input int mx,
                           input int f, input int l);
    check({tag, ".vld"},   int'(vld_out), 1);
    check({tag, ".diff"},  int'(diff_out), d);
    check({tag, ".mdiff"}, int'(mdiff_out), md);
    check({tag, ".max"},   int'(max_out), mx);
    check({tag, ".first"}, int'(first_out), f);
    check({tag, ".last"},  int'(last_out), l);
  endtask

  // Offer one score with rdy_in=1 and check the result one edge later.
  task automatic push_chk(input string tag, input int s, input int d, input int md,
                          input int mx, input int f, input int l);
    @(negedge clock);
    vld_in = 1'b1;
    rdy_in = 1'b1;
    s_in   = 8'(s);
    @(posedge clock);
    #1;
    check_res(tag, d, md, mx, f, l);
  endtask

  task automatic go_idle();
    @(negedge clock);
    vld_in = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b0;
    vld_in = 1'b1;
    rdy_in = 1'b1;
    s_in   = 8'sd99;
    repeat (2) @(posedge clock);
    #1;
    check("rst.vld_out", int'(vld_out), 0);
    check("rst.diff",    int'(diff_out), 0);
    check("rst.mdiff",   int'(mdiff_out), 0);
    check("rst.max",     int'(max_out), 0);
    check("rst.first",   int'(first_out), 0);
    check("rst.last",    int'(last_out), 0);
    @(negedge clock);
    vld_in = 1'b0;
    reset  = 1'b1;
    #1;
    check("rst.rdy_out", int'(rdy_out), 1);

    push_chk("row0", 10,   0,   0, 10, 1, 0);
    push_chk("row1", 30,   0, -20, 30, 0, 0);
    push_chk("row2", 20, -10,   0, 30, 0, 0);
    push_chk("row3", 40,   0, -10, 40, 0, 1);
    push_chk("nxt0",  5,   0,   0,  5, 1, 0);
    push_chk("nxt1",  6,   0,  -1,  6, 0, 0);
    push_chk("nxt2",  7,   0,  -1,  7, 0, 0);
    push_chk("nxt3",  1,  -6,   0,  7, 0, 1);

    push_chk("satd0",  127,    0, 0, 127, 1, 0);
    push_chk("satd1", -128, -128, 0, 127, 0, 0);
    push_chk("satd2",    0, -127, 0, 127, 0, 0);
    push_chk("satd3",    0, -127, 0, 127, 0, 1);

    push_chk("satm0", -128, 0,    0, -128, 1, 0);
    push_chk("satm1",  127, 0, -128,  127, 0, 0);
    push_chk("satm2",  127, 0,    0,  127, 0, 0);
    push_chk("satm3",  127, 0,    0,  127, 0, 1);

    // Backpressure: hold the result for 3 cycles while a new score waits.
    push_chk("bp0", 50, 0, 0, 50, 1, 0);
    @(negedge clock);
    rdy_in = 1'b0;
    vld_in = 1'b1;
    s_in   = 8'sd60;
    #1;
    check("bp.rdy_out", int'(rdy_out), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("bp.hold_rdy", int'(rdy_out), 0);
      check_res("bp.hold", 0, 0, 50, 1, 0);
    end
    push_chk("bp1", 60,   0, -10, 60, 0, 0);
    push_chk("bp2", 40, -20,   0, 60, 0, 0);
    push_chk("bp3", 70,   0, -10, 70, 0, 1);
    go_idle();
    check("idle.vld_out", int'(vld_out), 0);
    check("idle.max",     int'(max_out), 70);
    check("idle.last",    int'(last_out), 1);

    // Mid-row reset discards the partial row.
    push_chk("mr0", 30, 0,   0, 30, 1, 0);
    push_chk("mr1", 50, 0, -20, 50, 0, 0);
    @(negedge clock);
    vld_in = 1'b0;
    reset  = 1'b0;
    #1;
    check("mr.vld_out", int'(vld_out), 0);
    check("mr.max",     int'(max_out), 0);
    @(negedge clock);
    reset = 1'b1;
    push_chk("mr7", 7, 0, 0, 7, 1, 0);
    push_chk("mr8", 9, 0, -2, 9, 0, 0);
    push_chk("mr9", 1, -8, 0, 9, 0, 0);
    push_chk("mrA", 2, -7, 0, 9, 0, 1);

    // Two rows back to back at full throughput.
    push_chk("tp0",  3,  0,  0,  3, 1, 0);
    push_chk("tp1",  9,  0, -6,  9, 0, 0);
    push_chk("tp2",  2, -7,  0,  9, 0, 0);
    push_chk("tp3",  8, -1,  0,  9, 0, 1);
    push_chk("tp4", -5,  0,  0, -5, 1, 0);
    push_chk("tp5", -1,  0, -4, -1, 0, 0);
    push_chk("tp6", -7, -6,  0, -1, 0, 0);
    push_chk("tp7",  4,  0, -5,  4, 0, 1);
    go_idle();
    check("end.vld_out", int'(vld_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
